// File: rtl/alu_op_sequencer.sv
// Control and operand/result register stage in front of the one-hot logic ALU.
// Legal op: EXEC then DONE; illegal op goes straight to DONE. DONE holds until out_ready. ALU_SEQ_STATS_EN enables op_count.
module alu_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] Rb,
    output logic [DATA_W-1:0] Ry,
    output logic              AND,
    output logic              OR,
    output logic              NEG,
    output logic              NOT,
    input  logic [DATA_W-1:0] resultLo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] z_out,
    output logic              err,
    output logic [15:0]       op_count
);

    localparam logic [OPC_W-1:0] OPC_AND = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OPC_OR  = OPC_W'(5'b00110);
    localparam logic [OPC_W-1:0] OPC_NEG = OPC_W'(5'b10000);
    localparam logic [OPC_W-1:0] OPC_NOT = OPC_W'(5'b10001);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [OPC_W-1:0]  r_opc;
    logic [DATA_W-1:0] r_rb;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_z;
    logic              r_err;
    logic              w_accept;
    logic              w_legal;
    logic              w_handoff;

    assign w_legal   = (opcode == OPC_AND) || (opcode == OPC_OR) ||
                       (opcode == OPC_NEG) || (opcode == OPC_NOT);
    assign w_accept  = in_valid && in_ready;
    assign w_handoff = out_valid && out_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = w_legal ? S_EXEC : S_DONE;
            S_EXEC: w_next_state = S_DONE;
            S_DONE: if (w_handoff) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Selects are only ever raised in EXEC, which illegal opcodes never reach.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        AND       = 1'b0;
        OR        = 1'b0;
        NEG       = 1'b0;
        NOT       = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_EXEC: begin
                AND = (r_opc == OPC_AND);
                OR  = (r_opc == OPC_OR);
                NEG = (r_opc == OPC_NEG);
                NOT = (r_opc == OPC_NOT);
            end
            S_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_opc <= '0;
            r_rb  <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opc <= opcode;
                r_rb  <= a_in;
                r_y   <= b_in;
                if (!w_legal) begin
                    r_z   <= '0;
                    r_err <= 1'b1;
                end
            end
            if (r_state == S_EXEC) begin
                r_z   <= resultLo;
                r_err <= 1'b0;
            end
        end
    end

    assign Rb    = r_rb;
    assign Ry    = r_y;
    assign z_out = r_z;
    assign err   = r_err;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_op_count <= '0;
        end else if (w_handoff && !r_err && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`else
    assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; includes a combinational model of the one-hot ALU.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] Rb;
    logic [31:0] Ry;
    logic        w_and;
    logic        w_or;
    logic        w_neg;
    logic        w_not;
    logic [31:0] resultLo;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z_out;
    logic        err;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(32), .OPC_W(5)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a_in(a_in), .b_in(b_in), .Rb(Rb), .Ry(Ry),
        .AND(w_and), .OR(w_or), .NEG(w_neg), .NOT(w_not),
        .resultLo(resultLo), .out_valid(out_valid), .out_ready(out_ready),
        .z_out(z_out), .err(err), .op_count(op_count)
    );

    always_comb begin
        resultLo = 32'h0;
        if (w_and)      resultLo = Rb & Ry;
        else if (w_or)  resultLo = Rb | Ry;
        else if (w_neg) resultLo = ~Rb + 32'd1;
        else if (w_not) resultLo = ~Rb;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; in_valid = 1'b1; opcode = 5'b00101; a_in = 32'h1; b_in = 32'h1; out_ready = 1'b1;
        repeat (2) step();
        n_checks++;
        if ({in_ready, out_valid, w_and, w_or, w_neg, w_not, err} !== 7'b1000000) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 1000000", {in_ready, out_valid, w_and, w_or, w_neg, w_not, err});
        end
        n_checks++;
        if ({Rb, Ry, z_out, op_count} !== {96'h0, 16'h0}) begin
            n_fail++; $display("FAIL reset_regs Rb=%h Ry=%h z=%h cnt=%h want all 0", Rb, Ry, z_out, op_count);
        end
        in_valid = 1'b0;
        #3 clr = 1'b0;
        step();
    endtask

    task automatic test_and();
        out_ready = 1'b1; in_valid = 1'b1; opcode = 5'b00101; a_in = 32'hF0F0_1234; b_in = 32'h0FF0_FFFF;
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({w_and, w_or, w_neg, w_not, out_valid, in_ready} !== 6'b100000) begin
            n_fail++; $display("FAIL and_exec sel/vld/rdy got %b want 100000", {w_and, w_or, w_neg, w_not, out_valid, in_ready});
        end
        n_checks++;
        if ({Rb, Ry} !== {32'hF0F0_1234, 32'h0FF0_FFFF}) begin
            n_fail++; $display("FAIL and_operands Rb=%h Ry=%h want f0f01234 0ff0ffff", Rb, Ry);
        end
        step();
        n_checks++;
        if ({out_valid, err, w_and, z_out} !== {3'b100, 32'h00F0_1234}) begin
            n_fail++; $display("FAIL and_done vld=%b err=%b and=%b z=%h want 1 0 0 00f01234", out_valid, err, w_and, z_out);
        end
        step();
        n_checks++;
        if ({out_valid, in_ready, z_out} !== {2'b01, 32'h00F0_1234}) begin
            n_fail++; $display("FAIL and_idle vld=%b rdy=%b z=%h want 0 1 00f01234", out_valid, in_ready, z_out);
        end
    endtask

    task automatic test_neg_not();
        in_valid = 1'b1; opcode = 5'b10000; a_in = 32'h0000_0005; b_in = 32'h1234_5678;
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({w_and, w_or, w_neg, w_not} !== 4'b0010) begin
            n_fail++; $display("FAIL neg_sel got %b want 0010", {w_and, w_or, w_neg, w_not});
        end
        step();
        n_checks++;
        if ({out_valid, err, z_out} !== {2'b10, 32'hFFFF_FFFB}) begin
            n_fail++; $display("FAIL neg_result vld=%b err=%b z=%h want 1 0 fffffffb", out_valid, err, z_out);
        end
        step();
        in_valid = 1'b1; opcode = 5'b10001; a_in = 32'h0; b_in = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({w_and, w_or, w_neg, w_not} !== 4'b0001) begin
            n_fail++; $display("FAIL not_sel got %b want 0001", {w_and, w_or, w_neg, w_not});
        end
        step();
        n_checks++;
        if ({out_valid, err, z_out} !== {2'b10, 32'hFFFF_FFFF}) begin
            n_fail++; $display("FAIL not_result vld=%b err=%b z=%h want 1 0 ffffffff", out_valid, err, z_out);
        end
        step();
    endtask

    task automatic test_illegal();
        logic [15:0] cnt_before;
        cnt_before = op_count;
        in_valid = 1'b1; opcode = 5'b11111; a_in = 32'hDEAD_BEEF; b_in = 32'hCAFE_F00D;
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, err, z_out} !== {2'b11, 32'h0}) begin
            n_fail++; $display("FAIL illegal_done vld=%b err=%b z=%h want 1 1 0", out_valid, err, z_out);
        end
        n_checks++;
        if ({w_and, w_or, w_neg, w_not} !== 4'b0000) begin
            n_fail++; $display("FAIL illegal_sel_done got %b want 0000", {w_and, w_or, w_neg, w_not});
        end
        step();
        n_checks++;
        if ({out_valid, in_ready, w_and, w_or, w_neg, w_not} !== 6'b010000) begin
            n_fail++; $display("FAIL illegal_idle got %b want 010000", {out_valid, in_ready, w_and, w_or, w_neg, w_not});
        end
        n_checks++;
        if (op_count !== cnt_before) begin
            n_fail++; $display("FAIL illegal_count got %h want %h", op_count, cnt_before);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; opcode = 5'b00110; a_in = 32'hA; b_in = 32'h5;
        step();
        opcode = 5'b00101; a_in = 32'hFFFF_0000; b_in = 32'h00FF_00FF;
        step();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({out_valid, in_ready, z_out, Rb} !== {2'b10, 32'hF, 32'hA}) begin
                n_fail++; $display("FAIL bp_hold cyc %0d vld=%b rdy=%b z=%h Rb=%h want 1 0 f a", i, out_valid, in_ready, z_out, Rb);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if ({out_valid, in_ready, Rb, z_out} !== {2'b01, 32'hA, 32'hF}) begin
            n_fail++; $display("FAIL bp_handoff vld=%b rdy=%b Rb=%h z=%h want 0 1 a f", out_valid, in_ready, Rb, z_out);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({w_and, Rb} !== {1'b1, 32'hFFFF_0000}) begin
            n_fail++; $display("FAIL bp_second_accept and=%b Rb=%h want 1 ffff0000", w_and, Rb);
        end
        step();
        n_checks++;
        if ({out_valid, z_out} !== {1'b1, 32'h00FF_0000}) begin
            n_fail++; $display("FAIL bp_second_result vld=%b z=%h want 1 00ff0000", out_valid, z_out);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; opcode = 5'b00110; a_in = 32'h1; b_in = 32'h2;
        step();
        a_in = 32'h6;
        step();
        step();
        n_checks++;
        if ({in_ready, Rb, z_out} !== {1'b1, 32'h1, 32'h3}) begin
            n_fail++; $display("FAIL b2b_idle rdy=%b Rb=%h z=%h want 1 1 3", in_ready, Rb, z_out);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({w_or, Rb} !== {1'b1, 32'h6}) begin
            n_fail++; $display("FAIL b2b_second_accept or=%b Rb=%h want 1 6", w_or, Rb);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid_op();
        bit seen_valid;
        seen_valid = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; opcode = 5'b00110; a_in = 32'h3; b_in = 32'h4;
        step();
        in_valid = 1'b0;
        #2 clr = 1'b1;
        #1;
        n_checks++;
        if ({w_or, out_valid, in_ready, Rb, Ry, z_out} !== {3'b001, 96'h0}) begin
            n_fail++; $display("FAIL rst_mid or=%b vld=%b rdy=%b Rb=%h Ry=%h z=%h want 0 0 1 0 0 0", w_or, out_valid, in_ready, Rb, Ry, z_out);
        end
        #1 clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_output out_valid seen=%b want 0", seen_valid);
        end
        in_valid = 1'b1; opcode = 5'b00110; a_in = 32'hC; b_in = 32'h3;
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if ({out_valid, err, z_out} !== {2'b10, 32'hF}) begin
            n_fail++; $display("FAIL rst_mid_next_op vld=%b err=%b z=%h want 1 0 f", out_valid, err, z_out);
        end
        step();
    endtask

    task automatic run_ops_for_stats(input int n, output bit timed_out);
        logic [4:0] opcs [4] = '{5'b00101, 5'b11111, 5'b00110, 5'b10001};
        int waited;
        timed_out = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1; opcode = opcs[k % 4]; a_in = 32'h55 + k; b_in = 32'h0F;
            step();
            in_valid = 1'b0;
            waited = 0;
            while (!out_valid && waited < 5) begin
                step();
                waited++;
            end
            if (!out_valid) timed_out = 1'b1;
            step();
        end
    endtask

    task automatic test_stats();
        bit to;
        clr = 1'b1; out_ready = 1'b1;
        #2 clr = 1'b0;
        step();
        run_ops_for_stats(4, to);
        n_checks++;
        if (to !== 1'b0) begin
            n_fail++; $display("FAIL stats_timeout out_valid never rose");
        end
`ifdef ALU_SEQ_STATS_EN
        n_checks++;
        if (op_count !== 16'd3) begin
            n_fail++; $display("FAIL stats_count got %h want 0003", op_count);
        end
        force dut.r_op_count = 16'hFFFF;
        step();
        release dut.r_op_count;
        run_ops_for_stats(1, to);
        n_checks++;
        if (op_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL stats_saturate got %h want ffff", op_count);
        end
`else
        n_checks++;
        if (op_count !== 16'h0000) begin
            n_fail++; $display("FAIL stats_disabled got %h want 0000", op_count);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_and();
        test_neg_not();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream control-and-register stage for the one-hot logic ALU (AND/OR/NEG/NOT selects, 32-bit operands Rb/Ry, result resultLo). Accepts an operation request over a valid/ready handshake and latches the operands into the Rb and Y registers. It then drives exactly one ALU select for one cycle, captures resultLo into the Z register, and presents the result over a valid/ready output handshake. One operation is in flight at a time; there is no pipelining.

Parameters:
DATA_W, 32, operand/result width; must match the ALU width.
OPC_W, 5, opcode field width.

Ports:
clk  input  1  system clock, rising edge.
clr  input  1  reset, asynchronous, active-high.
in_valid  input  1  request valid.
in_ready  output  1  sequencer can accept a request; high only in IDLE.
opcode  input  OPC_W  operation code: 5'b00101 AND, 5'b00110 OR, 5'b10000 NEG, 5'b10001 NOT; all other codes are illegal.
a_in  input  DATA_W  operand A, latched into rb_reg and driven to the ALU Rb input.
b_in  input  DATA_W  operand B, latched into y_reg and driven to the ALU Ry input.
Rb  output  DATA_W  ALU operand (rb_reg).
Ry  output  DATA_W  ALU operand (y_reg).
AND, OR, NEG, NOT  output  1 each  one-hot ALU selects.
resultLo  input  DATA_W  ALU result, combinational from Rb/Ry/selects.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
z_out  output  DATA_W  captured result (z_reg).
err  output  1  qualifies z_out; high = illegal opcode.
op_count  output  16  completed-operation counter (see Optional Feature).

Behaviour:
- Reset (clr=1, async): state=IDLE. rb_reg, y_reg, z_reg, opc_reg, err and op_count all 0. All selects 0. out_valid=0. in_ready=1 (IDLE), but requests are ignored while clr=1. A reset mid-operation aborts it silently with no output.
- States: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: latch opcode->opc_reg, a_in->rb_reg, b_in->y_reg.
  - Legal opcode: next state EXEC.
  - Illegal opcode: z_reg<=0, err<=1, next state DONE. No select is ever asserted for an illegal opcode.
- EXEC (exactly 1 cycle):
  - Exactly one of AND/OR/NEG/NOT is high, decoded from opc_reg; all selects are 0 in every other state.
  - At the EXEC-exit edge: z_reg<=resultLo, err<=0, next state DONE.
- DONE:
  - out_valid=1; z_out and err are held stable until out_ready.
  - On an edge with out_valid&out_ready: next state IDLE. out_valid drops the following cycle.
  - in_ready=0 in DONE, so a new request cannot be accepted in the handoff cycle. The earliest next accept is the cycle after returning to IDLE.
- Latency:
  - Legal op: accept edge -> out_valid high 2 cycles later (EXEC then DONE).
  - Illegal op: out_valid high 1 cycle after the accept edge.
  - Minimum issue interval: 3 cycles with out_ready held at 1.
- Holding registers:
  - Rb/Ry keep their values after the operation until the next accept, so the ALU output stays stable.
  - z_out holds its last value in IDLE.
- Back-pressure: with out_ready=0, DONE is held indefinitely; in_valid is ignored throughout.
- Width rules: no arithmetic in the block except op_count; the ALU's NEG (two's complement) and NOT operate on Rb only.

Optional Feature:
ALU_SEQ_STATS_EN:
- Defined: op_count increments by 1 on each DONE->IDLE handoff with err=0. It saturates at 16'hFFFF and is cleared by clr.
- Undefined: op_count is tied to 16'h0000 and no counter flops are instantiated.

Test Plan:
AND: a_in=32'hF0F0_1234, b_in=32'h0FF0_FFFF, opcode=00101, out_ready=1 -> only AND pulses high for 1 cycle; out_valid 2 cycles after accept; z_out=32'h00F0_1234, err=0.
NEG: a_in=32'h0000_0005, opcode=10000 -> NEG pulses; z_out=32'hFFFF_FFFB. Then NOT with a_in=32'h0000_0000 -> z_out=32'hFFFF_FFFF.
Illegal opcode 5'b11111 -> no select ever asserted; out_valid 1 cycle after accept; err=1, z_out=0; op_count unchanged.
Back-pressure: OR a=32'hA,b=32'h5, out_ready=0 for 10 cycles, with in_valid=1 and a new request presented -> z_out=32'hF held, in_ready=0, second request accepted only after the handoff and the return to IDLE.
Reset mid-op: assert clr during EXEC -> outputs clear immediately (async), out_valid never rises, state IDLE; the next OR completes normally.
ALU_SEQ_STATS_EN defined: 3 legal ops + 1 illegal -> op_count=3. Preload the counter via force to 16'hFFFF, run 1 op -> stays 16'hFFFF.
